dma_bytelane_master: RTL and testbench

//  Block-copy engine that initiates transfers on the split even/odd byte-lane memory/IO bus.

---
 rtl/dma_bytelane_master_pkg.sv | 26 ++
 rtl/dma_bytelane_master_if.sv | 30 +++
 rtl/dma_bytelane_master_chunk_planner.sv | 31 +++
 rtl/dma_bytelane_master.sv | 188 ++++++++++++++++++
 tb/tb_dma_bytelane_master.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dma_bytelane_master_pkg.sv
// Shared types for the byte-lane DMA master: FSM states, chunk descriptor,
// and the lane-routing helper used by the write stage.
package dma_pkg;

    localparam int unsigned DMA_ADDR_W_DEF = 15;
    localparam int unsigned DMA_LEN_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dma_state_t;

    // lane_mask: lanes read for this chunk (bit0 = even, bit1 = odd).
    // swap: a single byte read on one lane is written on the other lane.
    typedef struct packed {
        logic [1:0] lane_mask;
        logic       swap;
    } dma_chunk_t;

    // Lanes that receive write strobes for a chunk.
    function automatic logic [1:0] write_lanes(input dma_chunk_t c);
        return c.swap ? {c.lane_mask[0], c.lane_mask[1]} : c.lane_mask;
    endfunction

endpackage

// File: rtl/dma_bytelane_master_if.sv
// Split even/odd byte-lane bus. The DMA master drives addresses and writes;
// the memory/IO side returns registered read data one cycle after the address.
interface dma_bytelane_master_if #(
    parameter int unsigned ADDR_W = 15
);
    logic [ADDR_W-1:0] read_addr_even;
    logic [ADDR_W-1:0] read_addr_odd;
    logic [7:0]        read_data_even;
    logic [7:0]        read_data_odd;
    logic [ADDR_W-1:0] write_addr_even;
    logic [7:0]        write_data_even;
    logic              write_en_even;
    logic [ADDR_W-1:0] write_addr_odd;
    logic [7:0]        write_data_odd;
    logic              write_en_odd;

    modport master (
        output read_addr_even, read_addr_odd,
        input  read_data_even, read_data_odd,
        output write_addr_even, write_data_even, write_en_even,
        output write_addr_odd, write_data_odd, write_en_odd
    );

    modport slave (
        input  read_addr_even, read_addr_odd,
        output read_data_even, read_data_odd,
        input  write_addr_even, write_data_even, write_en_even,
        input  write_addr_odd, write_data_odd, write_en_odd
    );
endinterface

// File: rtl/dma_bytelane_master_chunk_planner.sv
// Combinational chunk planner: picks a two-byte pair when both addresses are
// word aligned, at least two bytes remain and the destination increments;
// otherwise a single byte on the source lane, routed to the destination lane.
module dma_chunk_planner
    import dma_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             src_lsb,
    input  logic             dst_lsb,
    input  logic [LEN_W-1:0] rem,
    input  logic             dst_fixed,
    output dma_chunk_t       chunk,
    output logic [1:0]       size
);

    // Pair vs single-byte decision and lane routing
    always_comb begin
        chunk = '0;
        size  = 2'd1;
        if (!src_lsb && !dst_lsb && (rem[LEN_W-1:1] != '0) && !dst_fixed) begin
            chunk.lane_mask = 2'b11;
            chunk.swap      = 1'b0;
            size            = 2'd2;
        end else begin
            chunk.lane_mask = src_lsb ? 2'b10 : 2'b01;
            chunk.swap      = src_lsb ^ dst_lsb;
        end
    end

endmodule

// File: rtl/dma_bytelane_master.sv
// Block-copy initiator on the split even/odd byte-lane bus.
// Pipeline: issue (read address) -> data (responder registers the byte)
// -> write (registered write strobes). One chunk per cycle.
module dma_bytelane_master
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W:0]       src,
    input  logic [ADDR_W:0]       dst,
    input  logic [LEN_W-1:0]      len,
    input  logic                  dst_fixed,
    dma_bytelane_master_if.master bus,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BA_W = ADDR_W + 1;

    dma_state_t        state, next_state;
    logic [BA_W-1:0]   src_r, dst_r;
    logic [LEN_W-1:0]  rem_r;
    logic              fixed_r;

    logic [BA_W-1:0]   cur_src, cur_dst;
    logic [LEN_W-1:0]  cur_rem;
    logic              cur_fixed;
    dma_chunk_t        p_chunk;
    logic [1:0]        p_size;

    logic              accept, issue, done_next, busy_next;

    logic              rd_v;
    dma_chunk_t        rd_chunk;
    logic [ADDR_W-1:0] rd_waddr;
    logic              dv;
    dma_chunk_t        d_chunk;
    logic [ADDR_W-1:0] d_waddr;
    logic [1:0]        d_wlanes;

    logic [ADDR_W-1:0] ra_even, ra_odd, wa_even, wa_odd;
    logic [7:0]        wd_even, wd_odd;
    logic              we_even, we_odd;

    // The first chunk is planned from the start inputs so its read address
    // is already on the bus in the first RUN cycle.
    always_comb begin
        cur_src   = src_r;
        cur_dst   = dst_r;
        cur_rem   = rem_r;
        cur_fixed = fixed_r;
        if (state == IDLE) begin
            cur_src   = src;
            cur_dst   = dst;
            cur_rem   = len;
            cur_fixed = dst_fixed;
        end
    end

    dma_chunk_planner #(.LEN_W(LEN_W)) u_planner (
        .src_lsb   (cur_src[0]),
        .dst_lsb   (cur_dst[0]),
        .rem       (cur_rem),
        .dst_fixed (cur_fixed),
        .chunk     (p_chunk),
        .size      (p_size)
    );

    // Next-state, issue and completion decode
    always_comb begin
        next_state = state;
        accept     = (state == IDLE) && start && !abort && (len != '0);
        issue      = accept || ((state == RUN) && !abort && (rem_r != '0));
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) next_state = RUN;
                done_next = start && !abort && (len == '0);
            end
            RUN: begin
                if (abort)              next_state = IDLE;
                else if (rem_r == '0)   next_state = DRAIN;
            end
            DRAIN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (!rd_v && !dv) begin
                    next_state = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        busy_next = (next_state != IDLE);
    end

    // FSM state and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // Issue stage: drive read addresses and advance the byte counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_r    <= '0;
            dst_r    <= '0;
            rem_r    <= '0;
            fixed_r  <= 1'b0;
            ra_even  <= '0;
            ra_odd   <= '0;
            rd_v     <= 1'b0;
            rd_chunk <= '0;
            rd_waddr <= '0;
        end else begin
            rd_v <= issue;
            if (issue) begin
                if (p_chunk.lane_mask[0]) ra_even <= cur_src[ADDR_W:1];
                if (p_chunk.lane_mask[1]) ra_odd  <= cur_src[ADDR_W:1];
                src_r    <= cur_src + BA_W'(p_size);
                dst_r    <= cur_fixed ? cur_dst : cur_dst + BA_W'(p_size);
                rem_r    <= cur_rem - LEN_W'(p_size);
                fixed_r  <= cur_fixed;
                rd_chunk <= p_chunk;
                rd_waddr <= cur_dst[ADDR_W:1];
            end
        end
    end

    always_comb d_wlanes = write_lanes(d_chunk);

    // Data and write stages: capture returned bytes into the write registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dv      <= 1'b0;
            d_chunk <= '0;
            d_waddr <= '0;
            wa_even <= '0;
            wa_odd  <= '0;
            wd_even <= '0;
            wd_odd  <= '0;
            we_even <= 1'b0;
            we_odd  <= 1'b0;
        end else begin
            dv      <= rd_v && !abort;
            d_chunk <= rd_chunk;
            d_waddr <= rd_waddr;
            we_even <= 1'b0;
            we_odd  <= 1'b0;
            wd_even <= '0;
            wd_odd  <= '0;
            if (dv && !abort) begin
                if (d_wlanes[0]) begin
                    we_even <= 1'b1;
                    wa_even <= d_waddr;
                    wd_even <= d_chunk.swap ? bus.read_data_odd : bus.read_data_even;
                end
                if (d_wlanes[1]) begin
                    we_odd <= 1'b1;
                    wa_odd <= d_waddr;
                    wd_odd <= d_chunk.swap ? bus.read_data_even : bus.read_data_odd;
                end
            end
        end
    end

    assign bus.read_addr_even  = ra_even;
    assign bus.read_addr_odd   = ra_odd;
    assign bus.write_addr_even = wa_even;
    assign bus.write_data_even = wd_even;
    assign bus.write_en_even   = we_even;
    assign bus.write_addr_odd  = wa_odd;
    assign bus.write_data_odd  = wd_odd;
    assign bus.write_en_odd    = we_odd;

endmodule

// File: tb/tb_dma_bytelane_master.sv
// Bench for dma_bytelane_master: byte-addressed memory responder, write log
// monitor, and a copy model (byte i of src lands at dst+i, or at dst when fixed).
module tb_dma_bytelane_master;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        start     = 1'b0;
    logic        abort     = 1'b0;
    logic        dst_fixed = 1'b0;
    logic [15:0] src       = '0;
    logic [15:0] dst       = '0;
    logic [15:0] len       = '0;
    logic        busy, done;

    dma_bytelane_master_if #(.ADDR_W(15)) bus ();

    dma_bytelane_master #(.ADDR_W(15), .LEN_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .dst_fixed (dst_fixed),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: registered reads, byte writes per lane
    logic [7:0] mem [0:65535];
    logic       filled = 1'b0;
    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
            mem[16'h0100] <= 8'h11;
            mem[16'h0101] <= 8'h22;
            mem[16'h0102] <= 8'h33;
            mem[16'h0103] <= 8'h44;
            filled <= 1'b1;
        end else begin
            if (bus.write_en_even) mem[{bus.write_addr_even, 1'b0}] <= bus.write_data_even;
            if (bus.write_en_odd)  mem[{bus.write_addr_odd, 1'b1}]  <= bus.write_data_odd;
        end
        bus.read_data_even <= mem[{bus.read_addr_even, 1'b0}];
        bus.read_data_odd  <= mem[{bus.read_addr_odd, 1'b1}];
    end

    // Monitor: log every written byte as {byte address, data}
    logic [23:0] wlog [$];
    int unsigned beats    = 0;
    int unsigned done_cnt = 0;
    always @(negedge clk) begin
        if (bus.write_en_even) wlog.push_back({bus.write_addr_even, 1'b0, bus.write_data_even});
        if (bus.write_en_odd)  wlog.push_back({bus.write_addr_odd, 1'b1, bus.write_data_odd});
        if (bus.write_en_even || bus.write_en_odd) beats <= beats + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {busy, done, bus.read_addr_even, bus.read_addr_odd,
                  bus.write_addr_even, bus.write_addr_odd, bus.write_data_even,
                  bus.write_data_odd, bus.write_en_even, bus.write_en_odd}, 80'd0);
    endtask

    // Chunk count from the planning rules, independent of any RTL state
    function automatic int unsigned n_chunks(input logic [15:0] s, input logic [15:0] d,
                                             input int unsigned l, input logic f);
        if (l == 0) return 0;
        if (f || (s[0] != d[0])) return l;
        if (s[0]) return 1 + l / 2;
        return (l + 1) / 2;
    endfunction

    int unsigned k0, wbase, bbase, dbase;
    logic [23:0] expq [$];

    task automatic launch(input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic f);
        @(negedge clk);
        src = s; dst = d; len = l; dst_fixed = f; start = 1'b1;
        k0 = cyc; wbase = wlog.size(); bbase = beats; dbase = done_cnt;
        expq.delete();
        for (int unsigned i = 0; i < l; i++)
            expq.push_back({16'(d + (f ? 16'd0 : 16'(i))), mem[16'(s + 16'(i))]});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned exp_lat,
                             input int unsigned exp_beats);
        int unsigned n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
        chk({tag, "_latency"}, cyc - k0, exp_lat);
        @(negedge clk);
        chk({tag, "_done_1cycle"}, done, 1'b0);
        chk({tag, "_busy_after"}, busy, 1'b0);
        @(negedge clk);
        chk({tag, "_nwrites"}, wlog.size() - wbase, expq.size());
        for (int unsigned i = 0; i < expq.size(); i++)
            chk({tag, "_write"}, (wbase + i < wlog.size()) ? wlog[wbase + i] : 24'hxxxxxx, expq[i]);
        chk({tag, "_beats"}, beats - bbase, exp_beats);
        chk({tag, "_done_count"}, done_cnt - dbase, 1);
    endtask

    task automatic xfer(input string tag, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] l, input logic f);
        int unsigned c;
        c = n_chunks(s, d, l, f);
        launch(s, d, l, f);
        chk({tag, "_busy_first"}, busy, (l != 0));
        wait_done(tag, (l == 0) ? 1 : c + 3, c);
    endtask

    initial begin
        logic [15:0] rs, rd;
        logic [15:0] rl;
        logic        rf;
        int unsigned wcnt;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("idle_outputs");

        // Aligned pair copy with read address trace
        launch(16'h0100, 16'h0200, 16'd4, 1'b0);
        chk("t1_ra_even_0", bus.read_addr_even, 15'h080);
        chk("t1_ra_odd_0",  bus.read_addr_odd,  15'h080);
        @(negedge clk);
        chk("t1_ra_even_1", bus.read_addr_even, 15'h081);
        chk("t1_ra_odd_1",  bus.read_addr_odd,  15'h081);
        wait_done("t1", 5, 2);
        chk("t1_mem200", mem[16'h0200], 8'h11);
        chk("t1_mem201", mem[16'h0201], 8'h22);
        chk("t1_mem202", mem[16'h0202], 8'h33);
        chk("t1_mem203", mem[16'h0203], 8'h44);

        // Mismatched parity: single-byte beats with lane swap
        xfer("t2", 16'h0101, 16'h0300, 16'd3, 1'b0);

        // Zero length
        xfer("t3", 16'h0100, 16'h0400, 16'd0, 1'b0);

        // Fixed destination register
        xfer("t4", 16'h0100, 16'h002A, 16'd3, 1'b1);

        // Address wrap on source, then on destination with odd equal parity
        xfer("wrap_src", 16'hFFFE, 16'h4000, 16'd4, 1'b0);
        xfer("wrap_dst", 16'h2001, 16'hFFFF, 16'd3, 1'b0);

        // Abort in the third RUN cycle
        launch(16'h0400, 16'h0800, 16'd16, 1'b0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_we_even", bus.write_en_even, 1'b0);
        chk("t5_we_odd",  bus.write_en_odd,  1'b0);
        chk("t5_busy",    busy, 1'b0);
        wcnt = wlog.size();
        repeat (25) @(negedge clk);
        chk("t5_no_writes", wlog.size(), wcnt);
        chk("t5_no_done",   done_cnt, dbase);
        xfer("t5_restart", 16'h0600, 16'h0A00, 16'd7, 1'b0);

        // Asynchronous reset mid-transfer
        launch(16'h0500, 16'h0900, 16'd12, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_all_zero("t6_async_reset");
        src = 16'h0100; dst = 16'h0C00; len = 16'd4; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        chk_all_zero("t6_start_in_reset");
        reset = 1'b1;
        @(negedge clk);
        chk("t6_idle_busy", busy, 1'b0);
        xfer("t6_after", 16'h0700, 16'h0B00, 16'd5, 1'b0);

        // Randomized transfers against the copy model
        for (int i = 0; i < 10; i++) begin
            rs = 16'($urandom_range(0, 32'h7F00));
            rd = 16'(rs + 16'h0100 + 16'($urandom_range(0, 255)));
            rl = 16'($urandom_range(1, 24));
            rf = 1'($urandom_range(0, 1));
            xfer("rand", rs, rd, rl, rf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
